// File: rtl/nes_pkg.sv
// NES controller reader shared definitions: FSM states, button bit positions, 74.25 MHz defaults.
// Latency: n/a (package).
// Backpressure: n/a (package).
package nes_pkg;

    // Read sequencer states, in the order they are visited during one read.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETTLE = 3'd2,
        CLK_HI = 3'd3,
        CLK_LO = 3'd4,
        DONE   = 3'd5
    } nes_state_t;

    // Bit positions in the button vector; this is also the order the pad shifts them out.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // 74.25 MHz pixel clock: ~6 us half-bit, 60 Hz poll rate.
    localparam int HALF_PERIOD_DEFAULT = 446;
    localparam int POLL_PERIOD_DEFAULT = 1237500;

endpackage

// File: rtl/nes_controller_reader_if.sv
// Bundles the request/result and pad-side pins of the NES controller reader.
// Latency: n/a (wires only).
// Backpressure: none; poll requests arriving while busy are dropped by the reader.
// Signals: poll (request), nesData (pad serial, active-low), nesLatch/nesClock (pad strobes),
//          buttons (pressed=1), valid (update pulse), busy (read in progress).
interface nes_controller_reader_if;
    logic       poll;
    logic       nesData;
    logic       nesLatch;
    logic       nesClock;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    // Host side: issues requests, owns the pad data pin, consumes results.
    modport master (
        output poll,
        output nesData,
        input  nesLatch,
        input  nesClock,
        input  buttons,
        input  valid,
        input  busy
    );

    // Reader side.
    modport slave (
        input  poll,
        input  nesData,
        output nesLatch,
        output nesClock,
        output buttons,
        output valid,
        output busy
    );
endinterface

// File: rtl/nes_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to a configurable idle level.
// Latency: 2 cycles from pin to sync_o.
// Backpressure: none.
// Ports: clock, reset (sync, active-high), async_i (raw pin), sync_o (synchronized level).
module nes_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Polls an NES pad over latch/clock/data and publishes an 8-bit pressed-high button vector.
// Latency: 17*HALF_PERIOD+1 cycles from accepted request to valid pulse.
// Backpressure: none; requests seen while a read is in progress are dropped, not queued.
// Ports: clock, reset (sync, active-high), io (slave modport: poll, nesData, nesLatch, nesClock,
//        buttons, valid, busy).
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,  // >= 3
    parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT,  // > 17*HALF_PERIOD+1
    parameter bit AUTO_POLL   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    nes_controller_reader_if.slave  io
);

    // One counter covers every timed state; the longest is the 2H latch pulse.
    localparam int CNT_W = $clog2(2 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);

    localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    // ------------------------------------------------------------------
    // Data pin: synchronize, then flip to pressed-high. The synchronizer
    // idles at 1 so a pad that is absent or in reset reads as released.
    // ------------------------------------------------------------------
    logic data_sync;
    logic pressed;

    nes_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (io.nesData),
        .sync_o  (data_sync)
    );

    assign pressed = ~data_sync;

    // ------------------------------------------------------------------
    // Frame-rate poll timer. Free-running regardless of FSM state so the
    // poll cadence never drifts with read length.
    // ------------------------------------------------------------------
    logic tmr_req;

    generate
        if (AUTO_POLL) begin : g_timer
            localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);
            logic [TMR_W-1:0] tmr_q;
            logic [TMR_W-1:0] tmr_d;

            always_comb begin
                tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    tmr_q <= '0;
                end else begin
                    tmr_q <= tmr_d;
                end
            end

            assign tmr_req = (tmr_q == TMR_LAST);
        end else begin : g_no_timer
            assign tmr_req = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    nes_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]     idx_q,   idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     buttons_q, buttons_d;
    logic           latch_q, latch_d;
    logic           nclk_q,  nclk_d;
    logic           valid_q, valid_d;
    logic           busy_q,  busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                // Manual and timer requests in the same cycle merge into one read.
                if (io.poll || tmr_req) begin
                    state_d = LATCH;
                    cnt_d   = LATCH_LAST;
                end
            end

            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = HALF_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SETTLE: begin
                // The pad presents A as soon as the latch drops; take it
                // at the end of the settle window, before any clock pulse.
                if (cnt_q == '0) begin
                    shift_d[BTN_A] = pressed;
                    idx_d          = 3'd1;
                    state_d        = CLK_HI;
                    cnt_d          = HALF_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            CLK_HI: begin
                if (cnt_q == '0) begin
                    state_d = CLK_LO;
                    cnt_d   = HALF_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            CLK_LO: begin
                // Sample late in the low phase so the bit shifted out on the
                // preceding rising edge has crossed the synchronizer.
                if (cnt_q == '0) begin
                    shift_d[idx_q] = pressed;
                    if (idx_q == 3'd7) begin
                        state_d   = DONE;
                        // Registered here so the new vector is visible in the
                        // same cycle as the valid pulse.
                        buttons_d = shift_d;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = CLK_HI;
                        cnt_d   = HALF_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Pad-facing and status outputs are registered from the next state
        // so they line up with state_q and never glitch.
        latch_d = (state_d == LATCH);
        nclk_d  = (state_d == CLK_HI);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            nclk_q    <= nclk_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign io.nesLatch = latch_q;
    assign io.nesClock = nclk_q;
    assign io.buttons  = buttons_q;
    assign io.valid    = valid_q;
    assign io.busy     = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: manual-poll instance with a pad model, plus an auto-poll instance.
// Latency: checks the 17H+1 request-to-valid timing with H=4.
// Backpressure: checks that requests during a read are dropped.
module tb_nes_controller_reader;

    localparam int H  = 4;
    localparam int PP = 200;
    localparam int RD = 17 * H + 1;   // 69

    logic clock = 1'b0;
    logic reset_m;
    logic reset_a;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    nes_controller_reader_if m_if ();
    nes_controller_reader_if a_if ();

    nes_controller_reader #(
        .HALF_PERIOD (H),
        .POLL_PERIOD (PP),
        .AUTO_POLL   (1'b0)
    ) dut_m (
        .clock (clock),
        .reset (reset_m),
        .io    (m_if)
    );

    nes_controller_reader #(
        .HALF_PERIOD (H),
        .POLL_PERIOD (PP),
        .AUTO_POLL   (1'b1)
    ) dut_a (
        .clock (clock),
        .reset (reset_a),
        .io    (a_if)
    );

    // ---------------- pad model (manual instance) ----------------
    // mode 0: shift pat (pin = complement, LSB first, advance on clock rise)
    // mode 1: line tied high, mode 2: line tied low
    logic [7:0] pat  = 8'h00;
    logic [1:0] mode = 2'd0;
    logic [3:0] mdl_idx = 4'd0;

    always @(posedge m_if.nesLatch) mdl_idx = 4'd0;
    always @(posedge m_if.nesClock) mdl_idx = mdl_idx + 4'd1;

    assign m_if.nesData = (mode == 2'd1) ? 1'b1 :
                          (mode == 2'd2) ? 1'b0 :
                          (mdl_idx < 4'd8) ? ~pat[mdl_idx[2:0]] : 1'b0;

    // Auto instance sees every button held.
    assign a_if.nesData = 1'b0;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] btn;
        int         cyc;
    } exp_t;

    exp_t q_m[$];
    exp_t q_a[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (m_if.valid) begin
            if (q_m.size() == 0) begin
                check("m_unexpected_valid", 1, 0);
            end else begin
                e = q_m.pop_front();
                check("m_buttons", int'(m_if.buttons), int'(e.btn));
                check("m_valid_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (a_if.valid) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 1, 0);
            end else begin
                e = q_a.pop_front();
                check("a_buttons", int'(a_if.buttons), int'(e.btn));
                check("a_valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one manual poll at the current negedge and wait for it to finish.
    task automatic read_m(input logic [7:0] exp_btn, input int wait_cycles);
        q_m.push_back('{btn: exp_btn, cyc: cyc + RD});
        m_if.poll = 1'b1;
        @(negedge clock);
        m_if.poll = 1'b0;
        repeat (wait_cycles - 1) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    logic lat_r [0:75];
    logic clk_r [0:75];
    logic bsy_r [0:75];

    initial begin
        int c;
        int r0;
        int lat_err, lat_cnt, clk_err, rises, bsy_err;

        m_if.poll = 1'b0;
        a_if.poll = 1'b0;
        reset_m   = 1'b1;
        reset_a   = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_latch",   int'(m_if.nesLatch), 0);
        check("rst_clock",   int'(m_if.nesClock), 0);
        check("rst_buttons", int'(m_if.buttons),  0);
        check("rst_valid",   int'(m_if.valid),    0);
        check("rst_busy",    int'(m_if.busy),     0);
        check("rst_a_busy",  int'(a_if.busy),     0);
        check("rst_a_valid", int'(a_if.valid),    0);

        reset_m = 1'b0;
        repeat (3) @(negedge clock);

        // Timing of latch/clock/busy plus pattern 0x5A
        pat  = 8'h5A;
        mode = 2'd0;
        c    = cyc;
        q_m.push_back('{btn: 8'h5A, cyc: c + RD});
        m_if.poll = 1'b1;
        lat_r[0] = 1'b0;
        clk_r[0] = 1'b0;
        bsy_r[0] = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clock);
            if (k == 1) m_if.poll = 1'b0;
            lat_r[k] = m_if.nesLatch;
            clk_r[k] = m_if.nesClock;
            bsy_r[k] = m_if.busy;
        end
        lat_err = 0; lat_cnt = 0; clk_err = 0; rises = 0; bsy_err = 0;
        for (int k = 1; k <= 75; k++) begin
            if (lat_r[k]) lat_cnt++;
            if (lat_r[k] !== (k >= 1 && k <= 8)) lat_err++;
            if (clk_r[k] !== (k >= 13 && k <= 68 && ((k - 13) % 8) < 4)) clk_err++;
            if (clk_r[k] && !clk_r[k-1]) rises++;
            if (k <= 68 && bsy_r[k] !== 1'b1) bsy_err++;
            if (k >= 70 && bsy_r[k] !== 1'b0) bsy_err++;
        end
        check("latch_high_cycles", lat_cnt, 8);
        check("latch_window_errs", lat_err, 0);
        check("nes_clock_pattern_errs", clk_err, 0);
        check("nes_clock_rises", rises, 7);
        check("busy_window_errs", bsy_err, 0);
        check("t1_pending", q_m.size(), 0);

        // Hold between reads
        repeat (5) @(negedge clock);
        check("hold_buttons", int'(m_if.buttons), 8'h5A);

        // Distinct patterns through the pad model
        pat = 8'h00; read_m(8'h00, 80);
        pat = 8'h81; read_m(8'h81, 80);
        pat = 8'h3C; read_m(8'h3C, 80);

        // Tied data line
        mode = 2'd1; read_m(8'h00, 80);
        mode = 2'd2; read_m(8'hFF, 80);
        mode = 2'd0;
        check("patterns_pending", q_m.size(), 0);

        // Request collisions: re-polls at 10 and 40 are dropped
        pat = 8'hC3;
        c   = cyc;
        q_m.push_back('{btn: 8'hC3, cyc: c + RD});
        m_if.poll = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clock);
            m_if.poll = (k == 10 || k == 40);
        end
        check("collide_pending", q_m.size(), 0);

        // Reset mid-read with buttons previously 0x5A
        pat = 8'h5A; read_m(8'h5A, 80);
        check("pre_abort_buttons", int'(m_if.buttons), 8'h5A);
        pat = 8'hFF;
        c   = cyc;
        q_m.push_back('{btn: 8'hFF, cyc: c + RD});
        m_if.poll = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            m_if.poll = 1'b0;
        end
        check("abort_busy_before", int'(m_if.busy), 1);
        reset_m = 1'b1;
        @(negedge clock);
        reset_m = 1'b0;
        q_m.delete();
        check("abort_latch",   int'(m_if.nesLatch), 0);
        check("abort_clock",   int'(m_if.nesClock), 0);
        check("abort_buttons", int'(m_if.buttons),  0);
        check("abort_busy",    int'(m_if.busy),     0);
        repeat (100) @(negedge clock);
        pat = 8'h24; read_m(8'h24, 80);
        check("after_abort_pending", q_m.size(), 0);

        // Auto poll: reads start at wraps 199, 399, ... -> valid at 268 + 200*j
        reset_a = 1'b0;
        r0 = cyc;
        for (int j = 0; j < 5; j++) q_a.push_back('{btn: 8'hFF, cyc: r0 + 268 + 200 * j});
        while (cyc < r0 + 1100) @(negedge clock);
        check("auto_pending", q_a.size(), 0);

        // Auto poll with io_poll coincident with the first wrap: one read only
        reset_a = 1'b1;
        @(negedge clock);
        reset_a = 1'b0;
        r0 = cyc;
        q_a.push_back('{btn: 8'hFF, cyc: r0 + 268});
        q_a.push_back('{btn: 8'hFF, cyc: r0 + 468});
        while (cyc < r0 + 500) begin
            @(negedge clock);
            a_if.poll = (cyc == r0 + 199);
        end
        a_if.poll = 1'b0;
        check("coincide_pending", q_a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
- Reads an NES gamepad over its native 3-wire serial interface: drives latch and clock, samples the serial data line, and presents an 8-bit button vector.
- Producer end of the NES button path. Its outputs feed the existing 8-channel debouncer ahead of the image output logic in the display top.
- Runs in the pixel clock domain (74.25 MHz for 720p).
- Polls automatically at frame rate, or on demand.

Parameters:
- HALF_PERIOD, 446: cycles per NES half-bit period (~6 us at 74.25 MHz). Must be >= 3.
- POLL_PERIOD, 1237500: cycles between automatic polls (60 Hz at 74.25 MHz). Must be > 17*HALF_PERIOD+1.
- AUTO_POLL, 1: 1 = free-running poll timer enabled; 0 = polls only on io_poll.

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- io_poll  in  1  one-cycle request to start a read
- io_nesData  in  1  serial data from controller; asynchronous; active-low (0 = pressed)
- io_nesLatch  out  1  latch strobe to controller
- io_nesClock  out  1  shift clock to controller
- io_buttons  out  8  pressed = 1. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
- io_valid  out  1  one-cycle pulse when io_buttons has been updated
- io_busy  out  1  high while a read is in progress

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: io_nesLatch=0, io_nesClock=0, io_buttons=0, io_valid=0, io_busy=0. State=IDLE, poll timer=0, bit index=0, synchronizer flops=1 (released).
- Input synchronizer:
  - io_nesData passes through a 2-flop synchronizer, then is inverted.
  - All sampling uses the synchronized value, so data lags the pin by 2 cycles.
- Poll timer (AUTO_POLL=1):
  - Counts 0..POLL_PERIOD-1 and wraps.
  - Raises an internal request on the wrap cycle.
  - Runs in every state.
- Start condition: a read starts when state is IDLE and (io_poll or timer request) is high.
  - Requests that arrive while busy are dropped, not queued.
  - io_poll and the timer request in the same cycle produce a single read.
- State machine (H = HALF_PERIOD; each timed state uses a down-counter loaded on entry):
  - IDLE: latch=0, clk=0, busy=0. On a request -> LATCH.
  - LATCH: latch=1 for 2H cycles -> SETTLE.
  - SETTLE: latch=0, clk=0 for H cycles. On the last cycle, sample bit 0 into shift[0] -> CLK_HI.
  - CLK_HI: clk=1 for H cycles -> CLK_LO.
  - CLK_LO: clk=0 for H cycles. On the last cycle, sample bit i into shift[i]. Then:
    - if i==7 -> DONE;
    - else i+1 and -> CLK_HI.
  - DONE: one cycle. io_buttons <= shift, io_valid=1 -> IDLE.
- Timing per read:
  - io_busy is high in every state except IDLE.
  - Request to io_valid: 1 + 2H + H + 7*2H = 17H+1 cycles.
  - io_valid asserts in the DONE cycle; io_buttons changes in that same cycle.
- Pulse count and hold:
  - Exactly 7 rising edges of io_nesClock per read.
  - io_buttons holds its last value between reads and while busy.
- Outputs io_nesLatch and io_nesClock come from registers, so they are glitch-free.
- Reset mid-read: the next cycle is in IDLE with latch and clk low, and io_buttons cleared. No io_valid is emitted for the aborted read.
- Disconnected controller: with the data line pulled high, the read completes normally with io_buttons=0x00.

Decomposition:
- Shared package nes_pkg:
  - state enum (IDLE, LATCH, SETTLE, CLK_HI, CLK_LO, DONE);
  - button index constants BTN_A..BTN_RIGHT (0..7);
  - default HALF_PERIOD and POLL_PERIOD constants for 74.25 MHz.
- Sub-module nes_sync: 2-flop synchronizer with a reset value of 1. It is reusable for other async button inputs.

Test Plan (H=4, POLL_PERIOD=200, AUTO_POLL=0 unless stated):
- Latch and clock timing: pulse io_poll at cycle 0 -> io_nesLatch high for exactly 8 cycles; 7 io_nesClock pulses, each 4 high / 4 low; io_valid at cycle 69; io_busy high in cycles 1..68.
- Controller model shifts 0b01011010 (active-high view; the pin carries the complement, LSB first, advancing on the clock rising edge) -> io_buttons=0x5A at io_valid; a second read with all released -> 0x00.
- Data line tied 1 -> io_buttons=0x00, io_valid still pulses once. Data line tied 0 -> io_buttons=0xFF.
- Request collisions: io_poll re-pulsed at cycles 10 and 40 -> ignored, exactly one io_valid. io_poll coincident with the timer wrap (AUTO_POLL=1) -> one read only.
- AUTO_POLL=1 with no io_poll for 1000 cycles -> reads start at timer wraps (cycle 199, then every 200 cycles), 5 io_valid pulses spaced 200 cycles apart.
- Reset asserted at cycle 30 mid-read with buttons previously 0x5A -> next cycle latch=0, clk=0, io_buttons=0, io_busy=0; no io_valid until a new io_poll.
